multicycle_processor: RTL and testbench
=======================================

Name: multicycle_processor

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I core.
- Executes an RV32I subset over several clocks per instruction, driven by an explicit FSM controller.
- Registered datapath: IR, A, B, ALUOut, MDR, PC. Same ALU-control encoding as the single-cycle core.
- Adds what the single-cycle core lacks: a run gate, an external instruction-load port, a done pulse, and parametrised width and memory depths.

Parameters:
- XLEN, 32, datapath and register width. Must be ≥ 32; instructions are always 32 bits.
- IMEM_DEPTH, 64, instruction memory words (power of 2).
- DMEM_DEPTH, 128, data memory words (power of 2).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- run  in  1  allows the FSM to leave FETCH
- imem_we  in  1  instruction memory write strobe; honoured only while in FETCH with run=0
- imem_addr  in  $clog2(IMEM_DEPTH)  word address for the load
- imem_wdata  in  32  instruction word to load
- Result  out  XLEN  ALUOut register
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- state  out  3  current FSM state, for debug

Behaviour:
- Reset (clk edge with reset=1):
  - PC=0, state=FETCH, Result=0, instr_done=0.
  - All registers x1..x31 cleared; x0 always reads 0. Writes to x0 are dropped.
  - Data memory and IMEM are not cleared.
  - Reset in any state aborts the instruction in flight; no register or memory write happens on that edge.
- State encoding: FETCH=0, DECODE=1, EXEC=2, ALUWB=3, MEMADDR=4, MEMRD=5, MEMWB=6, MEMWR=7.
- FETCH:
  - If run=1: IR<=IMEM[PC[..:2]], PC<=PC+4, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: A<=rs1, B<=rs2, then branch on opcode:
  - 0110011 or 0010011 → EXEC
  - 0000011 or 0100011 → MEMADDR
  - anything else → FETCH with instr_done=1 (NOP)
- EXEC:
  - ALUOut <= A op (B or sign-extended I-immediate).
  - Ops: add, sub, and, or, slt (signed), selected by funct3/funct7 as in the single-cycle core.
  - I-type supports addi, andi, ori, slti.
  - Then → ALUWB.
- ALUWB: rd<=ALUOut, instr_done=1, → FETCH.
- MEMADDR: ALUOut <= A + imm. Load uses the I-immediate, store the S-immediate.
  - 0000011 → MEMRD; 0100011 → MEMWR.
- MEMRD: MDR <= DMEM[ALUOut[..:2]], → MEMWB.
- MEMWB: rd<=MDR, instr_done=1, → FETCH.
- MEMWR: DMEM[ALUOut[..:2]] <= B, instr_done=1, → FETCH.
- Latency:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - unknown opcode: 2 cycles
- Memories:
  - Reads are combinational from arrays; writes are synchronous.
  - Addresses use word index modulo depth. Out-of-range addresses wrap silently; the low 2 bits are ignored.
- PC wraps modulo IMEM_DEPTH*4.
- Arithmetic wraps at XLEN; overflow is ignored.
- run dropping mid-instruction does not stall; it only holds the FSM in FETCH.
- imem_we while not in (FETCH and run=0) is ignored.

Optional Feature:
- Macro: MCPROC_BRANCH_EN.
- Defined:
  - beq/bne (opcode 1100011) are supported.
  - DECODE additionally computes ALUOut <= PC_old + B-immediate, where PC_old is the instruction's own address, kept in an OldPC register.
  - Then → BRANCH state (encoding widened to 4 bits; the state port becomes 4 bits).
  - BRANCH compares A and B; if taken, PC <= ALUOut. Then instr_done=1 → FETCH. 3 cycles.
- Undefined: 1100011 is treated as an unknown opcode (NOP, 2 cycles).

Decomposition:
- Package mcproc_pkg holds:
  - state enum
  - opcode constants
  - 4-bit ALU operation codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111
  - immediate-format selectors
- One natural sub-module: mcproc_fsm, which takes the opcode and state and produces the register/memory enables and ALU source selects.
- Datapath, register file and memories stay in the top module.

Test Plan:
- Reset after arbitrary activity → Result=0, state=0, PC=0; x5 reads 0.
- Load `addi x1,x0,5; addi x2,x0,7; add x3,x1,x2`, then run=1 → Result=12 on cycle 12; instr_done pulses at cycles 4, 8, 12.
- `sw x3,8(x0)` then `lw x4,8(x0)` → DMEM[2]=12 after 4 cycles; lw completes in 5 cycles and x4=12.
- `sub x5,x1,x2` → Result=0xFFFFFFFE; `slt x6,x1,x2` → x6=1; `addi x0,x0,9` → x0 stays 0.
- Opcode 0x7F → 2-cycle NOP; PC advances by 4 and no register changes.
- Assert reset during MEMWR → DMEM unchanged, state=FETCH.
- With MCPROC_BRANCH_EN defined: `beq x1,x1,-8` → PC returns to the prior instruction after 3 cycles.

Source files
------------

// File: rtl/mcproc_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset core.
// Optional feature macro: MCPROC_BRANCH_EN (adds beq/bne and a BRANCH state,
// widening the state encoding to 4 bits).
package mcproc_pkg;

`ifdef MCPROC_BRANCH_EN
   localparam int STATE_W = 4;
`else
   localparam int STATE_W = 3;
`endif

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 'd0,
      S_DECODE  = 'd1,
      S_EXEC    = 'd2,
      S_ALUWB   = 'd3,
      S_MEMADDR = 'd4,
      S_MEMRD   = 'd5,
      S_MEMWB   = 'd6,
      S_MEMWR   = 'd7
`ifdef MCPROC_BRANCH_EN
      ,S_BRANCH = 'd8
`endif
   } state_e;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_op_e;

   typedef enum logic [1:0] {
      IMM_I = 2'd0,
      IMM_S = 2'd1,
      IMM_B = 2'd2
   } imm_sel_e;

   // True for opcodes that do more than a 2-cycle NOP after DECODE.
   function automatic logic op_has_work(input logic [6:0] op);
      logic w;
      w = (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) || (op == OP_STORE);
`ifdef MCPROC_BRANCH_EN
      w = w || (op == OP_BRANCH);
`endif
      return w;
   endfunction

   // ALU operation from funct3/funct7; I-type never selects SUB.
   function automatic alu_op_e alu_control(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic       funct7_5);
      alu_op_e op;
      case (funct3)
         3'b000:  op = ((opcode == OP_RTYPE) && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b111:  op = ALU_AND;
         3'b110:  op = ALU_OR;
         3'b010:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mcproc_fsm.sv
// Controller for the multi-cycle core: state register, registered done pulse
// and per-state datapath enables. Optional feature macro: MCPROC_BRANCH_EN.
//
//   state   | meaning
//   FETCH   | wait for run; load IR from IMEM[PC], PC += 4
//   DECODE  | read rs1/rs2 into A/B, dispatch on opcode (unknown -> done)
//   EXEC    | ALUOut <= A op (B | I-imm)
//   ALUWB   | rd <= ALUOut, done
//   MEMADDR | ALUOut <= A + I/S-imm
//   MEMRD   | MDR <= DMEM[ALUOut]
//   MEMWB   | rd <= MDR, done
//   MEMWR   | DMEM[ALUOut] <= B, done
//   BRANCH  | compare A/B, PC <= ALUOut if taken, done (MCPROC_BRANCH_EN only)
module mcproc_fsm
   import mcproc_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [6:0]         fetch_opcode,
   input  logic [6:0]         ir_opcode,
   output logic [STATE_W-1:0] state,
   output logic               instr_done,
   output logic               ir_we,
   output logic               ab_we,
   output logic               aluout_we,
   output logic               target_we,
   output logic               mdr_we,
   output logic               rf_we,
   output logic               rf_from_mdr,
   output logic               dmem_we,
   output logic               alu_use_imm,
   output logic               alu_use_funct,
   output imm_sel_e           imm_sel,
   output logic               branch_state
);

   state_e state_q, state_d;
   logic   instr_done_q, instr_done_d;

   // Next state, plus a done flag for the state being entered.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (run) state_d = S_DECODE;
         S_DECODE: begin
            case (ir_opcode)
               OP_RTYPE, OP_ITYPE: state_d = S_EXEC;
               OP_LOAD, OP_STORE:  state_d = S_MEMADDR;
`ifdef MCPROC_BRANCH_EN
               OP_BRANCH:          state_d = S_BRANCH;
`endif
               default:            state_d = S_FETCH;
            endcase
         end
         S_EXEC:    state_d = S_ALUWB;
         S_MEMADDR: state_d = (ir_opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = S_MEMWB;
         default:   state_d = S_FETCH;
      endcase

      // DECODE is the final cycle of a NOP; its IR is the word being fetched now.
      case (state_d)
         S_ALUWB, S_MEMWB, S_MEMWR: instr_done_d = 1'b1;
`ifdef MCPROC_BRANCH_EN
         S_BRANCH:                  instr_done_d = 1'b1;
`endif
         S_DECODE:                  instr_done_d = !op_has_work(fetch_opcode);
         default:                   instr_done_d = 1'b0;
      endcase
   end

   // State and done-pulse registers; reset returns to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         instr_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         instr_done_q <= instr_done_d;
      end
   end

   // Datapath enables; suppressed on a reset edge so nothing is written.
   always_comb begin
      ir_we         = (state_q == S_FETCH) && run && !reset;
      ab_we         = (state_q == S_DECODE) && !reset;
      aluout_we     = ((state_q == S_EXEC) || (state_q == S_MEMADDR)) && !reset;
      mdr_we        = (state_q == S_MEMRD) && !reset;
      rf_we         = ((state_q == S_ALUWB) || (state_q == S_MEMWB)) && !reset;
      rf_from_mdr   = (state_q == S_MEMWB);
      dmem_we       = (state_q == S_MEMWR) && !reset;
      alu_use_imm   = (state_q == S_MEMADDR) || (ir_opcode == OP_ITYPE);
      alu_use_funct = (state_q == S_EXEC);
      imm_sel       = ((state_q == S_MEMADDR) && (ir_opcode == OP_STORE)) ? IMM_S : IMM_I;
`ifdef MCPROC_BRANCH_EN
      target_we     = (state_q == S_DECODE) && (ir_opcode == OP_BRANCH) && !reset;
      branch_state  = (state_q == S_BRANCH) && !reset;
`else
      target_we     = 1'b0;
      branch_state  = 1'b0;
`endif
   end

   assign state      = state_q;
   assign instr_done = instr_done_q;

endmodule

// File: rtl/multicycle_processor.sv
// Multi-cycle RV32I-subset core: registered datapath (PC, IR, A, B, ALUOut,
// MDR), register file and both memories; sequencing lives in mcproc_fsm.
// Optional feature macro: MCPROC_BRANCH_EN (beq/bne via OldPC + B-immediate).
module multicycle_processor
   import mcproc_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 128
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   input  logic [31:0]                   imem_wdata,
   output logic [XLEN-1:0]               Result,
   output logic                          instr_done,
   output logic [STATE_W-1:0]            state
);

   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int PCW = IAW + 2;
   localparam int DAW = $clog2(DMEM_DEPTH);

   logic [PCW-1:0]  pc_q, pc_d, oldpc_q, oldpc_d;
   logic [31:0]     ir_q, ir_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, mdr_q, mdr_d;

   logic [31:0]     imem_q [IMEM_DEPTH];
   logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
   logic [XLEN-1:0] rf_q   [32];

   logic ir_we, ab_we, aluout_we, target_we, mdr_we, rf_we, rf_from_mdr;
   logic dmem_we, alu_use_imm, alu_use_funct, branch_state;
   imm_sel_e imm_sel;

   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_val;
   logic [XLEN-1:0] alu_b, alu_y, rf_wdata;
   alu_op_e         alu_op;
   logic            br_taken, imem_wr;
   logic [31:0]     imem_rdata;

   mcproc_fsm u_fsm (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .fetch_opcode  (imem_rdata[6:0]),
      .ir_opcode     (ir_q[6:0]),
      .state         (state),
      .instr_done    (instr_done),
      .ir_we         (ir_we),
      .ab_we         (ab_we),
      .aluout_we     (aluout_we),
      .target_we     (target_we),
      .mdr_we        (mdr_we),
      .rf_we         (rf_we),
      .rf_from_mdr   (rf_from_mdr),
      .dmem_we       (dmem_we),
      .alu_use_imm   (alu_use_imm),
      .alu_use_funct (alu_use_funct),
      .imm_sel       (imm_sel),
      .branch_state  (branch_state)
   );

   // Instruction fields, immediates, register reads and the ALU.
   always_comb begin
      imem_rdata = imem_q[pc_q[PCW-1:2]];
      rs1 = ir_q[19:15];
      rs2 = ir_q[24:20];
      rd  = ir_q[11:7];
      rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
      rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

      imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
      imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      imm_val = (imm_sel == IMM_S) ? imm_s : imm_i;

      alu_b  = alu_use_imm ? imm_val : b_q;
      alu_op = alu_use_funct ? alu_control(ir_q[6:0], ir_q[14:12], ir_q[30]) : ALU_ADD;
      case (alu_op)
         ALU_AND: alu_y = a_q & alu_b;
         ALU_OR:  alu_y = a_q | alu_b;
         ALU_SUB: alu_y = a_q - alu_b;
         ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
         default: alu_y = a_q + alu_b;
      endcase

      case (ir_q[14:12])
         3'b000:  br_taken = (a_q == b_q);
         3'b001:  br_taken = (a_q != b_q);
         default: br_taken = 1'b0;
      endcase

      rf_wdata = rf_from_mdr ? mdr_q : aluout_q;
      imem_wr  = imem_we && !run && !reset && (state == S_FETCH);
   end

   // Next values of the datapath registers.
   always_comb begin
      pc_d     = pc_q;
      oldpc_d  = oldpc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      aluout_d = aluout_q;
      mdr_d    = mdr_q;
      if (ir_we) begin
         ir_d    = imem_rdata;
         oldpc_d = pc_q;
         pc_d    = pc_q + PCW'(4);
      end
      if (branch_state && br_taken) pc_d = aluout_q[PCW-1:0];
      if (ab_we) begin
         a_d = rs1_val;
         b_d = rs2_val;
      end
      if (aluout_we) aluout_d = alu_y;
      if (target_we) aluout_d = {{(XLEN-PCW){1'b0}}, oldpc_q} + imm_b;
      if (mdr_we)    mdr_d = dmem_q[aluout_q[DAW+1:2]];
   end

   // Datapath registers and register file; reset clears all of them.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         oldpc_q  <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         pc_q     <= pc_d;
         oldpc_q  <= oldpc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         mdr_q    <= mdr_d;
         if (rf_we && (rd != 5'd0)) rf_q[rd] <= rf_wdata;
      end
   end

   // Memory writes; contents survive reset.
   always_ff @(posedge clk) begin
      if (imem_wr) imem_q[imem_addr] <= imem_wdata;
      if (dmem_we) dmem_q[aluout_q[DAW+1:2]] <= b_q;
   end

   assign Result = aluout_q;

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed self-checking bench for multicycle_processor (default parameters).
module tb_multicycle_processor;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] Result;
   logic        instr_done;
`ifdef MCPROC_BRANCH_EN
   logic [3:0]  state;
`else
   logic [2:0]  state;
`endif

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] done_result;

   multicycle_processor dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .Result     (Result),
      .instr_done (instr_done),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic load_word(input int addr, input logic [31:0] w);
      imem_addr  = 6'(addr);
      imem_wdata = w;
      imem_we    = 1'b1;
      @(posedge clk); #1;
      imem_we    = 1'b0;
   endtask

   // Runs one instruction from FETCH; cyc counts FETCH as cycle 1, 99 on timeout.
   task automatic exec_one(output int cyc);
      cyc = 1;
      run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         run = 1'b0;
         cyc++;
         if (instr_done) break;
      end
      if (!instr_done) cyc = 99;
      done_result = Result;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; run = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (state !== 0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
      n_total++; if (Result !== 32'd0) $display("FAIL reset_result: got %h expected 0", Result); else n_pass++;
      n_total++; if (instr_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", instr_done); else n_pass++;
      n_total++; if (32'(dut.pc_q) !== 32'd0) $display("FAIL reset_pc: got %h expected 0", dut.pc_q); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic load_program;
      logic [31:0] prog [19];
      prog = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302423, 32'h00802203,
               32'h00020393, 32'h402082B3, 32'h0020A333, 32'h000304B3, 32'h00900013,
               32'h00000433, 32'h00A0E793, 32'h0020F833, 32'h0002A893, 32'h00000FFF,
               32'h00008513, 32'h000F85B3, 32'h00202623, 32'h00102623};
      for (int i = 0; i < 19; i++) load_word(i, prog[i]);
   endtask

   task automatic test_back_to_back;
      logic [11:0] seen;
      logic [31:0] res12;
      seen = '0;
      run = 1'b1;
      seen[0] = instr_done;
      for (int c = 2; c <= 12; c++) begin
         @(posedge clk); #1;
         seen[c-1] = instr_done;
      end
      res12 = Result;
      run = 1'b0;
      @(posedge clk); #1;
      n_total++; if (seen !== 12'b1000_1000_1000) $display("FAIL b2b_done_pattern: got %b expected 100010001000", seen); else n_pass++;
      n_total++; if (res12 !== 32'd12) $display("FAIL b2b_result_c12: got %h expected 0000000c", res12); else n_pass++;
   endtask

   task automatic test_mem;
      int cyc;
      exec_one(cyc);
      n_total++; if (cyc !== 4) $display("FAIL sw_latency: got %0d expected 4", cyc); else n_pass++;
      n_total++; if (dut.dmem_q[2] !== 32'd12) $display("FAIL sw_dmem2: got %h expected 0000000c", dut.dmem_q[2]); else n_pass++;
      exec_one(cyc);
      n_total++; if (cyc !== 5) $display("FAIL lw_latency: got %0d expected 5", cyc); else n_pass++;
      exec_one(cyc);
      n_total++; if (done_result !== 32'd12) $display("FAIL lw_x4: got %h expected 0000000c", done_result); else n_pass++;
   endtask

   task automatic test_alu;
      int cyc;
      logic [31:0] exp_res [8];
      string       nm [8];
      exp_res = '{32'hFFFFFFFE, 32'd1, 32'd1, 32'd9, 32'd0, 32'd15, 32'd5, 32'd1};
      nm      = '{"sub_x5", "slt_x6", "x6_readback", "addi_x0", "x0_readback",
                  "ori_x15", "and_x16", "slti_x17"};
      for (int i = 0; i < 8; i++) begin
         exec_one(cyc);
         n_total++;
         if (done_result !== exp_res[i] || cyc !== 4)
            $display("FAIL %s: got %h in %0d cycles expected %h in 4", nm[i], done_result, cyc, exp_res[i]);
         else n_pass++;
      end
   endtask

   task automatic test_nop;
      int cyc;
      exec_one(cyc);
      n_total++; if (cyc !== 2) $display("FAIL nop_latency: got %0d expected 2", cyc); else n_pass++;
      n_total++; if (Result !== 32'd1) $display("FAIL nop_result_held: got %h expected 00000001", Result); else n_pass++;
      n_total++; if (32'(dut.pc_q) !== 32'd60) $display("FAIL nop_pc: got %h expected 3c", dut.pc_q); else n_pass++;
      exec_one(cyc);
      n_total++; if (done_result !== 32'd5) $display("FAIL nop_x1_kept: got %h expected 00000005", done_result); else n_pass++;
      exec_one(cyc);
      n_total++; if (done_result !== 32'd0) $display("FAIL nop_x31_kept: got %h expected 0", done_result); else n_pass++;
   endtask

   task automatic test_reset_in_memwr;
      int cyc;
      exec_one(cyc);
      n_total++; if (dut.dmem_q[3] !== 32'd7) $display("FAIL sw_dmem3: got %h expected 00000007", dut.dmem_q[3]); else n_pass++;
      run = 1'b1;
      @(posedge clk); #1; run = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_total++; if (state !== 7) $display("FAIL reach_memwr: got %0d expected 7", state); else n_pass++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_total++; if (state !== 0) $display("FAIL memwr_reset_state: got %0d expected 0", state); else n_pass++;
      n_total++; if (dut.dmem_q[3] !== 32'd7) $display("FAIL memwr_reset_dmem3: got %h expected 00000007", dut.dmem_q[3]); else n_pass++;
      n_total++; if (32'(dut.pc_q) !== 32'd0 || Result !== 32'd0)
         $display("FAIL memwr_reset_pc_result: got pc %h result %h expected 0 0", dut.pc_q, Result);
      else n_pass++;
   endtask

   task automatic test_reset_after_activity;
      int cyc;
      bit seen_done;
      load_word(0, 32'h00028633);
      load_word(1, 32'h02100713);
      seen_done = 1'b0;
      run = 1'b1;
      @(posedge clk); #1; run = 1'b0;
      imem_addr = 6'd1; imem_wdata = 32'h06300713; imem_we = 1'b1;
      @(posedge clk); #1; imem_we = 1'b0;
      for (int i = 0; i < 10 && !seen_done; i++) begin
         if (instr_done) seen_done = 1'b1;
         else begin @(posedge clk); #1; end
      end
      n_total++; if (!seen_done || Result !== 32'd0)
         $display("FAIL x5_cleared: got %h done %b expected 0 done 1", Result, seen_done);
      else n_pass++;
      @(posedge clk); #1;
      exec_one(cyc);
      n_total++; if (done_result !== 32'd33) $display("FAIL imem_we_ignored: got %h expected 00000021", done_result); else n_pass++;
   endtask

   task automatic test_branch;
      int cyc;
      int exp_cyc, exp_pc1, exp_pc2;
`ifdef MCPROC_BRANCH_EN
      exp_cyc = 3; exp_pc1 = 0;  exp_pc2 = 4;
`else
      exp_cyc = 2; exp_pc1 = 12; exp_pc2 = 16;
`endif
      load_word(2, 32'hFE108CE3);
      load_word(0, 32'hFE109CE3);
      load_word(3, 32'hFE109CE3);
      exec_one(cyc);
      n_total++; if (cyc !== exp_cyc || 32'(dut.pc_q) !== 32'(exp_pc1))
         $display("FAIL beq: got %0d cycles pc %h expected %0d cycles pc %h", cyc, dut.pc_q, exp_cyc, exp_pc1);
      else n_pass++;
      exec_one(cyc);
      n_total++; if (cyc !== exp_cyc || 32'(dut.pc_q) !== 32'(exp_pc2))
         $display("FAIL bne_not_taken: got %0d cycles pc %h expected %0d cycles pc %h", cyc, dut.pc_q, exp_cyc, exp_pc2);
      else n_pass++;
   endtask

   initial begin
      test_reset;
      load_program;
      test_back_to_back;
      test_mem;
      test_alu;
      test_nop;
      test_reset_in_memwr;
      test_reset_after_activity;
      test_branch;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
